// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/OP/A/B/CHK frames from the UART byte stream and hands a
// checksum-verified {op, a, b} triple to the ALU over a valid/ready handshake.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [7:0] cmd_op,
    output logic [7:0] cmd_a,
    output logic [7:0] cmd_b,
    output logic       busy,
    output logic       err_checksum,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_OP,
        GET_A,
        GET_B,
        GET_CHK,
        HOLD
    } state_t;

    state_t           state;
    logic [7:0]       op_r;
    logic [7:0]       a_r;
    logic [7:0]       b_r;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= WAIT_SYNC;
            op_r         <= '0;
            a_r          <= '0;
            b_r          <= '0;
            cnt          <= '0;
            cmd_valid    <= 1'b0;
            cmd_op       <= '0;
            cmd_a        <= '0;
            cmd_b        <= '0;
            busy         <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
            case (state)
                WAIT_SYNC: begin
                    cnt <= '0;
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state <= GET_OP;
                        busy  <= 1'b1;
                    end
                end
                GET_OP, GET_A, GET_B, GET_CHK: begin
                    // An arriving byte always beats the timeout terminal count.
                    if (rx_valid) begin
                        cnt <= '0;
                        case (state)
                            GET_OP: begin
                                op_r  <= rx_data;
                                state <= GET_A;
                            end
                            GET_A: begin
                                a_r   <= rx_data;
                                state <= GET_B;
                            end
                            GET_B: begin
                                b_r   <= rx_data;
                                state <= GET_CHK;
                            end
                            default: begin
                                if (rx_data == (op_r ^ a_r ^ b_r)) begin
                                    state     <= HOLD;
                                    cmd_valid <= 1'b1;
                                    cmd_op    <= op_r;
                                    cmd_a     <= a_r;
                                    cmd_b     <= b_r;
                                end else begin
                                    state        <= WAIT_SYNC;
                                    busy         <= 1'b0;
                                    err_checksum <= 1'b1;
                                end
                            end
                        endcase
                    end else if (cnt == TERMINAL) begin
                        state       <= WAIT_SYNC;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    cnt <= '0;
                    // Bytes cannot be buffered while a command is pending.
                    if (rx_valid) begin
                        err_overrun <= 1'b1;
                    end
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_SYNC;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= WAIT_SYNC;
                    busy      <= 1'b0;
                    cmd_valid <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected commands are queued as frames
// are driven and compared whenever the parser presents a command.
module tb_uart_cmd_parser;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [7:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       busy;
    logic       err_checksum;
    logic       err_timeout;
    logic       err_overrun;

    uart_cmd_parser #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .busy        (busy),
        .err_checksum(err_checksum),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_csum   = 0;
    int n_tout   = 0;
    int n_ovr    = 0;
    int n_vcyc   = 0;
    int n_acc    = 0;
    int tout_cyc = -1;
    int rise_cyc = -1;
    int last_edge = 0;
    logic prev_v = 1'b0;
    logic [23:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: outputs and cmd_ready are both stable at the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_checksum) n_csum++;
            if (err_overrun)  n_ovr++;
            if (err_timeout) begin
                n_tout++;
                tout_cyc = cyc;
            end
            if (cmd_valid) begin
                n_vcyc++;
                if (!prev_v) rise_cyc = cyc;
                check("valid_has_expect", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("cmd_fields", {8'h00, cmd_op, cmd_a, cmd_b}, {8'h00, exp_q[0]});
                    if (cmd_ready) begin
                        void'(exp_q.pop_front());
                        n_acc++;
                    end
                end
            end
        end
        prev_v = cmd_valid;
    end

    task automatic put(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data   = b;
        rx_valid  = 1'b1;
        last_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input bit ok);
        if (ok) exp_q.push_back({o, a, b});
        put(8'hA5);
        put(o);
        put(a);
        put(b);
        put(c);
        idle(1);
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(tag, {3'b000, cmd_valid, busy, err_checksum, err_timeout, err_overrun,
                    cmd_op, cmd_a, cmd_b}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int e_csum, e_tout, e_ovr, e_vcyc, e_acc, e03, chk_edge;

    initial begin
        rst       = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("reset_outputs", {3'b000, cmd_valid, busy, err_checksum, err_timeout, err_overrun,
                                cmd_op, cmd_a, cmd_b}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Valid frame, ALU ready
        cmd_ready = 1'b1;
        e_vcyc = n_vcyc; e_acc = n_acc;
        frame(8'h02, 8'h15, 8'h0C, 8'h1B, 1);
        chk_edge = last_edge;
        idle(2);
        check("t1_valid_cycles", n_vcyc - e_vcyc, 1);
        check("t1_valid_latency", rise_cyc - chk_edge, 0);
        check("t1_accepts", n_acc - e_acc, 1);
        check("t1_busy_idle", busy, 0);

        // Bad checksum, then a good frame
        e_csum = n_csum; e_vcyc = n_vcyc; e_acc = n_acc;
        frame(8'h02, 8'h15, 8'h0C, 8'h1A, 0);
        idle(2);
        check("t2_csum_pulse", n_csum - e_csum, 1);
        check("t2_no_valid", n_vcyc - e_vcyc, 0);
        check("t2_busy_idle", busy, 0);
        frame(8'h02, 8'h15, 8'h0C, 8'h1B, 1);
        idle(2);
        check("t2_followup_accept", n_acc - e_acc, 1);

        // Garbage before sync
        e_csum = n_csum; e_tout = n_tout; e_ovr = n_ovr; e_acc = n_acc;
        put(8'h00);
        put(8'hFF);
        put(8'hA4);
        idle(2);
        check("t3_garbage_busy", busy, 0);
        frame(8'h07, 8'h01, 8'h02, 8'h04, 1);
        idle(2);
        check("t3_no_errors", (n_csum - e_csum) + (n_tout - e_tout) + (n_ovr - e_ovr), 0);
        check("t3_accept", n_acc - e_acc, 1);

        // Inter-byte timeout
        e_tout = n_tout; e_vcyc = n_vcyc;
        put(8'hA5);
        put(8'h03);
        e03 = last_edge;
        idle(25);
        check("t4_tout_pulse", n_tout - e_tout, 1);
        check("t4_tout_timing", tout_cyc - e03, 20);
        check("t4_busy_idle", busy, 0);
        check("t4_no_valid", n_vcyc - e_vcyc, 0);

        // Byte on the terminal cycle wins over the timeout
        e_tout = n_tout; e_acc = n_acc;
        exp_q.push_back({8'h03, 8'h11, 8'h22});
        put(8'hA5);
        put(8'h03);
        idle(19);
        put(8'h11);
        put(8'h22);
        put(8'h30);
        idle(3);
        check("t4_terminal_no_tout", n_tout - e_tout, 0);
        check("t4_terminal_accept", n_acc - e_acc, 1);

        // Backpressure with an overrun byte during HOLD
        cmd_ready = 1'b0;
        e_ovr = n_ovr; e_acc = n_acc;
        frame(8'h10, 8'h20, 8'h30, 8'h00, 1);
        idle(3);
        check("t5_hold_valid", cmd_valid, 1);
        check("t5_hold_busy", busy, 1);
        put(8'hA5);
        idle(5);
        check("t5_overrun_pulse", n_ovr - e_ovr, 1);
        check("t5_no_early_accept", n_acc - e_acc, 0);
        check("t5_still_valid", cmd_valid, 1);
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        idle(2);
        check("t5_single_accept", n_acc - e_acc, 1);
        check("t5_busy_idle", busy, 0);
        // A headerless but checksum-correct body must be ignored from WAIT_SYNC
        put(8'h07);
        put(8'h01);
        put(8'h02);
        put(8'h04);
        idle(3);
        check("t5_back_to_wait_sync", n_acc - e_acc, 1);
        check("t5_busy_after_body", busy, 0);

        // Overrun on the same cycle the command is accepted
        e_ovr = n_ovr; e_acc = n_acc;
        exp_q.push_back({8'h11, 8'h22, 8'h33});
        put(8'hA5);
        put(8'h11);
        put(8'h22);
        put(8'h33);
        put(8'h00);
        put(8'hA5);
        put(8'h07);
        put(8'h01);
        put(8'h02);
        put(8'h04);
        idle(3);
        check("t5_same_cycle_overrun", n_ovr - e_ovr, 1);
        check("t5_same_cycle_accept", n_acc - e_acc, 1);

        // Asynchronous reset mid-frame and during HOLD
        e_csum = n_csum; e_tout = n_tout; e_ovr = n_ovr; e_acc = n_acc;
        put(8'hA5);
        put(8'h02);
        idle(1);
        check("t6_midframe_busy", busy, 1);
        async_reset_check("t6_reset_midframe");
        cmd_ready = 1'b0;
        frame(8'h02, 8'h15, 8'h0C, 8'h1B, 1);
        idle(2);
        check("t6_hold_valid", cmd_valid, 1);
        async_reset_check("t6_reset_hold");
        cmd_ready = 1'b1;
        idle(2);
        check("t6_no_errors", (n_csum - e_csum) + (n_tout - e_tout) + (n_ovr - e_ovr), 0);
        frame(8'h07, 8'h01, 8'h02, 8'h04, 1);
        idle(3);
        check("t6_post_reset_accept", n_acc - e_acc, 1);

        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
